// File: rtl/rv32_m_mem_arbiter.sv
// Arbitrates one memory bus between fetch (IF) and load/store (D) requesters.
// Optional response timeout enabled by `RV32_MEM_ARB_TIMEOUT_EN.
module rv32_m_mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                err_o
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);

    if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("rv32_m_mem_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;    // 1 = D owns the bus, 0 = IF
    logic [3:0]  streak_q, streak_d;
    logic        sel_d;
    logic        resp_done;
    logic [DATA_W-1:0] resp_data;

`ifdef RV32_MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = 16;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        sel_d       = owner_q;
        mem_req_o   = 1'b0;
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        if_rvalid_o = 1'b0;
        d_rvalid_o  = 1'b0;
        if_rdata_o  = '0;
        d_rdata_o   = '0;
        err_o       = 1'b0;
        resp_done   = 1'b0;
        resp_data   = mem_rdata_i;
`ifdef RV32_MEM_ARB_TIMEOUT_EN
        to_cnt_d    = (state_q == RESP) ? to_cnt_q + 1'b1 : '0;
`endif

        case (state_q)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    // D wins unless IF has already waited out a full streak
                    sel_d     = d_req_i && !(if_req_i && streak_q == STREAK_MAX);
                    mem_req_o = 1'b1;
                    owner_d   = sel_d;
                    state_d   = mem_gnt_i ? RESP : ADDR;
                end
            end
            ADDR: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    resp_done = 1'b1;
                end
`ifdef RV32_MEM_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    resp_done = 1'b1;
                    resp_data = '0;
                    err_o     = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (mem_req_o && mem_gnt_i) begin
            if (sel_d) begin
                d_gnt_o = 1'b1;
                if (!if_req_i) begin
                    streak_d = '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + 4'd1;
                end
            end else begin
                if_gnt_o = 1'b1;
                streak_d = '0;
            end
        end

        if (resp_done) begin
            state_d = IDLE;
            if (owner_q) begin
                d_rvalid_o = 1'b1;
                d_rdata_o  = resp_data;
            end else begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = resp_data;
            end
        end
    end

    // Bus payload is zero whenever no request is presented
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (sel_d) begin
                mem_we_o    = d_we_i;
                mem_be_o    = d_be_i;
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
            end else begin
                mem_be_o    = {BE_W{1'b1}};
                mem_addr_o  = if_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

`ifdef RV32_MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

endmodule
